// File: rtl/board_pkg.sv
// Shared 2048 datapath definitions: move directions, tile width and helpers.
package board_pkg;

  localparam int TILE_W = 3;

  typedef enum logic [1:0] {
    DIR_LEFT  = 2'd0,
    DIR_RIGHT = 2'd1,
    DIR_UP    = 2'd2,
    DIR_DOWN  = 2'd3
  } dir_t;

  typedef enum logic {
    FILL  = 1'b0,
    DRAIN = 1'b1
  } orient_state_t;

  // Row counter width; a 1x1 board still needs a one-bit counter.
  function automatic int row_cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/board_orient_map.sv
// Combinational remap of one output row from a buffered N x N board so that
// the requested move becomes a canonical slide toward tile 0.
module board_orient_map
  import board_pkg::*;
#(
  parameter int N   = 3,
  parameter int W   = TILE_W,
  parameter int RCW = 2
) (
  input  logic [N*N*W-1:0] board,
  input  dir_t             dir,
  input  logic             undo,
  input  logic [RCW-1:0]   row,
  output logic [N*W-1:0]   row_out
);

  // Pick the source tile for every column of the requested output row.
  always_comb begin
    int r;
    int src;
    row_out = '0;
    r       = int'(row);
    src     = 0;
    for (int c = 0; c < N; c++) begin
      case (dir)
        DIR_LEFT:  src = r * N + c;
        DIR_RIGHT: src = r * N + (N - 1 - c);
        DIR_UP:    src = c * N + r;
        DIR_DOWN:  src = undo ? (c * N + (N - 1 - r)) : ((N - 1 - c) * N + r);
        default:   src = r * N + c;
      endcase
      row_out[c*W +: W] = board[src*W +: W];
    end
  end

endmodule

// File: rtl/board_orient.sv
// Row-serial board re-orienter: fills an N x N buffer one row per handshake,
// then drains it remapped for the latched direction and undo mode.
module board_orient
  import board_pkg::*;
#(
  parameter int N = 3,
  parameter int W = TILE_W
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N*W-1:0] in_row,
  input  logic [1:0]     in_dir,
  input  logic           in_undo,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [N*W-1:0] out_row,
  output logic           out_last
);

  localparam int             RCW      = row_cnt_width(N);
  localparam logic [RCW-1:0] LAST_ROW = RCW'(N - 1);

  orient_state_t    state;
  orient_state_t    next_state;
  logic [RCW-1:0]   rc;
  logic [N*N*W-1:0] buffer;
  dir_t             mode_dir;
  logic             mode_undo;
  logic             fill_hs;
  logic             drain_hs;

  // Handshakes qualified by state so fill and drain can never coincide.
  assign fill_hs  = (state == FILL)  && in_valid;
  assign drain_hs = (state == DRAIN) && out_ready;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= FILL;
    else     state <= next_state;
  end

  // Next-state and handshake outputs; outputs depend only on registered state.
  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    out_last   = 1'b0;
    case (state)
      FILL: begin
        in_ready = 1'b1;
        if (in_valid && rc == LAST_ROW) next_state = DRAIN;
      end
      DRAIN: begin
        out_valid = 1'b1;
        out_last  = (rc == LAST_ROW);
        if (out_ready && rc == LAST_ROW) next_state = FILL;
      end
      default: next_state = FILL;
    endcase
  end

  // Row counter shared by fill and drain; wraps to 0 after the last row.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rc <= '0;
    end else if (fill_hs || drain_hs) begin
      rc <= (rc == LAST_ROW) ? '0 : rc + RCW'(1);
    end
  end

  // Board buffer, written one row at a time during fill.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buffer <= '0;
    end else if (fill_hs) begin
      buffer[int'(rc)*N*W +: N*W] <= in_row;
    end
  end

  // Direction and undo are captured with row 0 and held for the whole board.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_dir  <= DIR_LEFT;
      mode_undo <= 1'b0;
    end else if (fill_hs && rc == '0) begin
      mode_dir  <= dir_t'(in_dir);
      mode_undo <= in_undo;
    end
  end

  board_orient_map #(
    .N  (N),
    .W  (W),
    .RCW(RCW)
  ) u_map (
    .board  (buffer),
    .dir    (mode_dir),
    .undo   (mode_undo),
    .row    (rc),
    .row_out(out_row)
  );

endmodule

// File: tb/tb_board_orient.sv
// Self-checking bench for board_orient: a 3x3 instance driven from a vector
// table, hand-written corner sequences and random boards against a
// transpose/mirror reference model, plus a 1x1 instance.
module tb_board_orient;

  typedef logic [2:0][8:0] board_t;

  typedef struct packed {
    logic [1:0] dir;
    logic       undo;
    board_t     board;
    board_t     expect_b;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;

  logic       in_valid, in_ready, in_undo, out_valid, out_ready, out_last;
  logic [8:0] in_row, out_row;
  logic [1:0] in_dir;

  logic       in_valid1, in_ready1, in_undo1, out_valid1, out_ready1, out_last1;
  logic [3:0] in_row1, out_row1;
  logic [1:0] in_dir1;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  board_orient #(.N(3), .W(3)) u_dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_row   (in_row),
    .in_dir   (in_dir),
    .in_undo  (in_undo),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_row  (out_row),
    .out_last (out_last)
  );

  board_orient #(.N(1), .W(4)) u_one (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid1),
    .in_ready (in_ready1),
    .in_row   (in_row1),
    .in_dir   (in_dir1),
    .in_undo  (in_undo1),
    .out_valid(out_valid1),
    .out_ready(out_ready1),
    .out_row  (out_row1),
    .out_last (out_last1)
  );

  function automatic logic [8:0] mk_row(input int t0, input int t1, input int t2);
    return {3'(t2), 3'(t1), 3'(t0)};
  endfunction

  function automatic board_t mk_board(input logic [8:0] r0, input logic [8:0] r1,
                                      input logic [8:0] r2);
    return {r2, r1, r0};
  endfunction

  function automatic vec_t mk_vec(input logic [1:0] d, input logic u,
                                  input board_t b, input board_t e);
    vec_t v;
    v.dir      = d;
    v.undo     = u;
    v.board    = b;
    v.expect_b = e;
    return v;
  endfunction

  // Reference: each mode is a composition of row mirror and transpose.
  function automatic board_t model(input board_t b, input logic [1:0] d, input logic u);
    int     t[3][3];
    int     s[3][3];
    board_t o;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) t[r][c] = int'(b[r][c*3 +: 3]);
    if (d == 2'd1 || (d == 2'd3 && u)) begin
      s = t;
      for (int r = 0; r < 3; r++) for (int c = 0; c < 3; c++) t[r][c] = s[r][2-c];
    end
    if (d == 2'd2 || d == 2'd3) begin
      s = t;
      for (int r = 0; r < 3; r++) for (int c = 0; c < 3; c++) t[r][c] = s[c][r];
    end
    if (d == 2'd3 && !u) begin
      s = t;
      for (int r = 0; r < 3; r++) for (int c = 0; c < 3; c++) t[r][c] = s[r][2-c];
    end
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) o[r][c*3 +: 3] = 3'(t[r][c]);
    return o;
  endfunction

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passed++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, req);
  endtask

  // Feed one 3-row board; rows 1 and 2 carry a different direction/undo.
  task automatic applyStimulus(input board_t b, input logic [1:0] d, input logic u,
                               input logic [1:0] alt_d, input logic alt_u);
    for (int r = 0; r < 3; r++) begin
      int n = 0;
      in_valid = 1'b1;
      in_row   = b[r];
      in_dir   = (r == 0) ? d : alt_d;
      in_undo  = (r == 0) ? u : alt_u;
      while (!in_ready && n < 20) begin
        step;
        n++;
      end
      if (!in_ready) checkOutput("in_ready wait", 32'(in_ready), 32'd1);
      if (r == 2) checkOutput("no out_valid before last row", 32'(out_valid), 32'd0);
      step;
    end
    in_valid = 1'b0;
    in_row   = '0;
    checkOutput("out_valid cycle after last input", 32'(out_valid), 32'd1);
  endtask

  // Drain and compare one board, with optional stall and input held in DRAIN.
  task automatic drain_board(input board_t e, input int stall_row, input int stall_cycles,
                             input bit hold_in, input string tag);
    for (int r = 0; r < 3; r++) begin
      int n = 0;
      while (!out_valid && n < 20) begin
        step;
        n++;
      end
      if (!out_valid) checkOutput($sformatf("%s out_valid wait", tag), 32'(out_valid), 32'd1);
      if (hold_in) begin
        in_valid = 1'b1;
        in_row   = 9'h1FF;
        checkOutput($sformatf("%s in_ready low in drain", tag), 32'(in_ready), 32'd0);
      end
      checkOutput($sformatf("%s row%0d", tag, r), 32'(out_row), 32'(e[r]));
      checkOutput($sformatf("%s last%0d", tag, r), 32'(out_last), 32'(r == 2));
      if (r == stall_row) begin
        repeat (stall_cycles) begin
          out_ready = 1'b0;
          step;
          checkOutput($sformatf("%s stall row%0d", tag, r), 32'(out_row), 32'(e[r]));
          checkOutput($sformatf("%s stall valid", tag), 32'(out_valid), 32'd1);
        end
      end
      out_ready = 1'b1;
      step;
      out_ready = 1'b0;
    end
    in_valid = 1'b0;
    checkOutput($sformatf("%s in_ready after drain", tag), 32'(in_ready), 32'd1);
    checkOutput($sformatf("%s out_valid after drain", tag), 32'(out_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vec_t       vecs[7];
    board_t     orig, down_b, rb, eb;
    logic [1:0] d;
    logic       u;
    logic [3:0] pending;
    int         outs;

    rst = 1'b1;
    in_valid = 0; in_row = '0; in_dir = '0; in_undo = 0; out_ready = 0;
    in_valid1 = 0; in_row1 = '0; in_dir1 = '0; in_undo1 = 0; out_ready1 = 0;

    orig   = mk_board(mk_row(1,2,3), mk_row(4,5,6), mk_row(7,0,1));
    down_b = mk_board(mk_row(7,4,1), mk_row(0,5,2), mk_row(1,6,3));
    vecs[0] = mk_vec(2'd0, 1'b0, orig, orig);
    vecs[1] = mk_vec(2'd1, 1'b0, orig, mk_board(mk_row(3,2,1), mk_row(6,5,4), mk_row(1,0,7)));
    vecs[2] = mk_vec(2'd2, 1'b0, orig, mk_board(mk_row(1,4,7), mk_row(2,5,0), mk_row(3,6,1)));
    vecs[3] = mk_vec(2'd3, 1'b0, orig, down_b);
    vecs[4] = mk_vec(2'd3, 1'b1, down_b, orig);
    vecs[5] = mk_vec(2'd2, 1'b1, orig, mk_board(mk_row(1,4,7), mk_row(2,5,0), mk_row(3,6,1)));
    vecs[6] = mk_vec(2'd1, 1'b1, orig, mk_board(mk_row(3,2,1), mk_row(6,5,4), mk_row(1,0,7)));

    #12;
    checkOutput("reset in_ready", 32'(in_ready), 32'd1);
    checkOutput("reset out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset out_last", 32'(out_last), 32'd0);
    checkOutput("reset out_row", 32'(out_row), 32'd0);
    checkOutput("reset n1 in_ready", 32'(in_ready1), 32'd1);
    checkOutput("reset n1 out_valid", 32'(out_valid1), 32'd0);
    rst = 1'b0;
    step;

    // Table-driven boards.
    for (int i = 0; i < 7; i++) begin
      applyStimulus(vecs[i].board, vecs[i].dir, vecs[i].undo, 2'($urandom), 1'($urandom));
      drain_board(vecs[i].expect_b, -1, 0, 1'b0, $sformatf("vec%0d", i));
    end

    // Back-pressure on row 1 of a RIGHT board.
    applyStimulus(orig, 2'd1, 1'b0, 2'd1, 1'b0);
    drain_board(vecs[1].expect_b, 1, 5, 1'b0, "stall");

    // Direction changes on later rows are ignored.
    applyStimulus(orig, 2'd2, 1'b0, 2'd3, 1'b1);
    drain_board(vecs[2].expect_b, -1, 0, 1'b0, "dirchg");

    // Input offered during DRAIN is refused.
    applyStimulus(orig, 2'd0, 1'b0, 2'd0, 1'b0);
    drain_board(orig, -1, 0, 1'b1, "holdin");
    applyStimulus(orig, 2'd1, 1'b0, 2'd0, 1'b0);
    drain_board(vecs[1].expect_b, -1, 0, 1'b0, "after holdin");

    // Asynchronous reset after two input rows, then a clean LEFT board.
    in_valid = 1'b1; in_dir = 2'd1; in_undo = 1'b0;
    in_row = mk_row(5,5,5); step;
    in_row = mk_row(6,6,6); step;
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    checkOutput("midfill rst in_ready", 32'(in_ready), 32'd1);
    checkOutput("midfill rst out_valid", 32'(out_valid), 32'd0);
    #2 rst = 1'b0;
    step;
    applyStimulus(orig, 2'd0, 1'b0, 2'd2, 1'b1);
    drain_board(orig, -1, 0, 1'b0, "after midfill rst");

    // Asynchronous reset in the middle of a drain.
    applyStimulus(orig, 2'd3, 1'b0, 2'd3, 1'b0);
    out_ready = 1'b1; step; out_ready = 1'b0;
    checkOutput("middrain row1", 32'(out_row), 32'(down_b[1]));
    rst = 1'b1;
    #1;
    checkOutput("middrain rst in_ready", 32'(in_ready), 32'd1);
    checkOutput("middrain rst out_valid", 32'(out_valid), 32'd0);
    checkOutput("middrain rst out_last", 32'(out_last), 32'd0);
    checkOutput("middrain rst out_row", 32'(out_row), 32'd0);
    #2 rst = 1'b0;
    step;
    applyStimulus(orig, 2'd2, 1'b0, 2'd0, 1'b0);
    drain_board(vecs[2].expect_b, -1, 0, 1'b0, "after middrain rst");

    // Random boards against the reference model.
    for (int i = 0; i < 20; i++) begin
      for (int r = 0; r < 3; r++) rb[r] = 9'($urandom);
      d  = 2'($urandom);
      u  = 1'($urandom);
      eb = model(rb, d, u);
      applyStimulus(rb, d, u, 2'($urandom), 1'($urandom));
      drain_board(eb, $urandom_range(0, 2), $urandom_range(0, 2), 1'($urandom),
                  $sformatf("rand%0d d%0d u%0d", i, d, u));
    end

    // 1x1 board: pass-through under every direction.
    for (int k = 0; k < 4; k++) begin
      in_valid1 = 1'b1; in_row1 = 4'd9; in_dir1 = 2'(k); in_undo1 = 1'($urandom);
      checkOutput($sformatf("n1 dir%0d in_ready", k), 32'(in_ready1), 32'd1);
      step;
      in_valid1 = 1'b0;
      checkOutput($sformatf("n1 dir%0d out_valid", k), 32'(out_valid1), 32'd1);
      checkOutput($sformatf("n1 dir%0d out_row", k), 32'(out_row1), 32'd9);
      checkOutput($sformatf("n1 dir%0d out_last", k), 32'(out_last1), 32'd1);
      out_ready1 = 1'b1; step; out_ready1 = 1'b0;
      checkOutput($sformatf("n1 dir%0d in_ready after", k), 32'(in_ready1), 32'd1);
    end

    // 1x1 streaming: one row every two cycles, data preserved.
    in_valid1 = 1'b1; out_ready1 = 1'b1; pending = '0; outs = 0;
    for (int i = 0; i < 20; i++) begin
      in_row1 = 4'($urandom); in_dir1 = 2'($urandom); in_undo1 = 1'($urandom);
      if (out_valid1) begin
        checkOutput($sformatf("n1 stream data%0d", i), 32'(out_row1), 32'(pending));
        outs++;
      end
      if (in_ready1) pending = in_row1;
      step;
    end
    in_valid1 = 1'b0; out_ready1 = 1'b0;
    checkOutput("n1 throughput", 32'(outs), 32'd10);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/board_orient.md
# board_orient

Row-serial, parametrised board re-orienter for the 2048 datapath. Accepts an N×N board of W-bit tile codes one row per handshake, buffers it, then emits it one row per handshake, remapped so that the requested move direction becomes a canonical "slide toward tile 0" for the merge engine. An `undo` bit applies the inverse mapping, so the same block can also restore the merged board to its original orientation.

## Interface
Parameters:
- `N`, 3, board dimension (rows = columns); legal values 1..8.
- `W`, 3, tile code width in bits.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `in_valid`  in  1  `in_row` holds a valid row.
- `in_ready`  out  1  block accepts a row this cycle.
- `in_row`  in  N*W  input row; tile c is `in_row[c*W +: W]`.
- `in_dir`  in  2  direction: 0 LEFT, 1 RIGHT, 2 UP, 3 DOWN; sampled with row 0 only.
- `in_undo`  in  1  0 applies the forward map, 1 applies the inverse map; sampled with row 0 only.
- `out_valid`  out  1  `out_row` holds a valid row.
- `out_ready`  in  1  consumer accepts the row this cycle.
- `out_row`  out  N*W  output row; tile c is `out_row[c*W +: W]`.
- `out_last`  out  1  high with the final (row N-1) output row of a board.

## Operation
- Input board `B[r][c]` is row r, tile c. Output row r, tile c is `O[r][c]`.
- Forward map (`undo`=0):
  - LEFT: `O=B[r][c]`.
  - RIGHT: `B[r][N-1-c]`.
  - UP: `B[c][r]`.
  - DOWN: `B[N-1-c][r]`.
- Inverse map (`undo`=1):
  - LEFT, RIGHT and UP: same as the forward map.
  - DOWN: `O=B[c][N-1-r]`.
- FSM states FILL and DRAIN. Row counter `rc` has width `max(1,$clog2(N))`.
- **FILL:**
  - `in_ready`=1 and `out_valid`=0.
  - Each accepted row (`in_valid`&`in_ready`) is written to buffer row `rc`, then `rc` increments.
  - On the row-0 handshake, `in_dir` and `in_undo` are latched. Their values at later handshakes are ignored.
  - On the handshake of row N-1: `rc` is cleared and the FSM moves to DRAIN.
- **DRAIN:**
  - `in_ready`=0 and `out_valid`=1.
  - `out_row` is the mapped row `rc`, computed from the buffer and the latched mode.
  - Each `out_valid`&`out_ready` handshake increments `rc`.
  - `out_last`=1 when `rc`==N-1. The handshake on that row clears `rc` and returns the FSM to FILL.
- Back-pressure: while `out_valid`&!`out_ready`, `out_row` and `out_last` hold stable.
- N=1: every board is a single row and passes through unchanged in all modes. FILL and DRAIN alternate on every handshake, and `out_last` is always 1 in DRAIN.
- Reset, including mid-board: FSM returns to FILL, `rc`=0, latched mode=LEFT/forward, buffer cleared to 0. A partially filled or drained board is discarded.

## Timing
- Reset values:
  - `in_ready`=1, `out_valid`=0, `out_last`=0, `out_row`=0.
- Outputs are derived only from registered state, with no combinational path from any input to any output.
- Latency: the first output row is valid the cycle after the row N-1 input handshake.
- Throughput: one board per 2N cycles with no stalls. Fill and drain do not overlap.
- After the last output handshake, `in_ready`=1 on the next cycle.
- No simultaneous input and output handshake is possible, because the FSM state makes them mutually exclusive.

## Structure
- Shared package `board_pkg`:
  - direction encodings `DIR_LEFT`/`DIR_RIGHT`/`DIR_UP`/`DIR_DOWN`;
  - `dir_t` typedef;
  - tile width default.
- The 2048 top level, merge engine and board_orient import the package.
- One combinational sub-module, `board_orient_map`:
  - inputs: N×N×W buffer, `dir`, `undo`, row index;
  - output: one mapped N*W-bit row.
- FSM, counter, buffer and handshake stay in the top module.

## Test plan
Defaults N=3, W=3. The input board is rows 0: {1,2,3}, 1: {4,5,6}, 2: {7,0,1}, written tile0..tile2.
- LEFT, forward → output rows {1,2,3}, {4,5,6}, {7,0,1}; `out_last` on row 2 only; first `out_valid` the cycle after the third input handshake.
- RIGHT, forward → {3,2,1}, {6,5,4}, {1,0,7}.
- UP → {1,4,7}, {2,5,0}, {3,6,1}. DOWN forward → {7,4,1}, {0,5,2}, {1,6,3}. Feeding the DOWN output back with `undo`=1 restores the original board.
- Stalls:
  - hold `out_ready`=0 for 5 cycles on row 1 → `out_row` stays {6,5,4} (RIGHT) and `out_valid`=1 throughout;
  - change `in_dir` on the row 1 and row 2 input handshakes → no effect on the mapping;
  - `in_valid` asserted during DRAIN → not accepted.
- Assert `rst` asynchronously after 2 input rows → `in_ready`=1 and `out_valid`=0 immediately; a new 3-row LEFT board then emerges intact.
- N=1, W=4: input {9} under each of the 4 directions → output {9}, `out_last`=1; back-to-back boards sustain one row every 2 cycles.
